div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port start, input, 1 bit: a DIV/DIVU instruction is in EX with operands valid.
REQ-004 SHALL have port is_signed, input, 1 bit: 1 = DIV, 0 = DIVU; sampled with start.
REQ-005 SHALL have port dividend, input, 32 bits: rs operand; sampled with start.
REQ-006 SHALL have port divisor, input, 32 bits: rt operand; sampled with start.
REQ-007 SHALL have port cancel, input, 1 bit: exception flush of EX; aborts any operation.
REQ-008 SHALL have port stall, output, 1 bit: feeds the hazard unit stall input; holds the pipeline while the divide is in flight.
REQ-009 SHALL have port done, output, 1 bit: feeds the hazard unit done input; one-cycle pulse, results valid.
REQ-010 SHALL have port hi, output, 32 bits: remainder.
REQ-011 SHALL have port lo, output, 32 bits: quotient.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 IDLE: start=1 and cancel=0 at a clock edge SHALL latch |dividend|, |divisor| (absolute values when is_signed=1, raw values otherwise), the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]), clear a 6-bit iteration counter, and go to BUSY.
REQ-014 IDLE: divisor==0 when start is accepted SHALL go directly to DONE with lo=32'hFFFFFFFF and hi=dividend (raw), for both signed and unsigned operation.
REQ-015 BUSY: the block SHALL perform one radix-2 restoring step per cycle, with a 33-bit partial remainder and one quotient bit per step, MSB first; after the 32nd step it SHALL go to DONE.
REQ-016 On the edge into DONE, the block SHALL register lo/hi; when is_signed=1, lo is negated if the quotient sign is 1 and hi is negated if the remainder sign is 1 (two's complement, 32-bit wrap).
REQ-017 DONE: done=1 for exactly one cycle, then unconditionally IDLE; start in DONE SHALL be ignored.
REQ-018 stall SHALL be combinational: 1 when (IDLE and start and not cancel) or BUSY; 0 in DONE, so the stalled instruction advances during the done cycle.
REQ-019 Latency: start accepted at edge N, done high in the cycle after edge N+32; divide-by-zero: done high in the cycle after edge N.
REQ-020 start in BUSY SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-021 cancel=1 at any edge SHALL force IDLE; no done pulse; stall deasserts in the following cycle; hi/lo keep prior values; cancel overrides a simultaneous start.
REQ-022 hi/lo SHALL hold their last completed result until the next completion.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (wrap, no trap).

Reset
REQ-024 rst=0 SHALL immediately, without a clock, force IDLE, counter=0, done=0, hi=0, lo=0, and latched operands to 0; stall then follows REQ-018 (0 unless start is high).
REQ-025 Reset asserted mid-operation SHALL abandon the operation; no done pulse after release.

Verification
REQ-026 DIVU 100/7: start 1 cycle -> stall=1 for 33 cycles, done in cycle 33, lo=14, hi=2.
REQ-027 DIV -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
REQ-028 DIVU 0x12345678/0 -> done in the cycle after the start edge, lo=0xFFFFFFFF, hi=0x12345678.
REQ-029 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0 after 33 cycles.
REQ-030 DIVU 100/7 with cancel=1 at BUSY cycle 10 -> stall=0 from the next cycle, no done, hi/lo unchanged; a new start is then accepted normally.
REQ-031 rst pulsed low mid-BUSY -> outputs 0 asynchronously, no done after release; a subsequent 9/3 gives lo=3, hi=0.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle radix-2 restoring divider for DIV/DIVU (hi=rem, lo=quo)
// Revision : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [5:0]  r_count;
    logic [31:0] r_dvd;     // dividend magnitude, shifted out MSB first; fills with quotient
    logic [31:0] r_dvs;
    logic [32:0] r_rem;
    logic        r_signed;
    logic        r_qsign;
    logic        r_rsign;

    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_qbit;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_lo_fin;
    logic [31:0] w_hi_fin;
    logic [31:0] w_abs_dvd;
    logic [31:0] w_abs_dvs;

    always_comb begin
        w_abs_dvd  = (is_signed && dividend[31]) ? -dividend : dividend;
        w_abs_dvs  = (is_signed && divisor[31])  ? -divisor  : divisor;
        // The partial remainder never exceeds 33 bits, so bit 33 of the
        // difference is a clean borrow flag for the restoring decision.
        w_shift    = {r_rem, r_dvd[31]};
        w_diff     = w_shift - {2'b00, r_dvs};
        w_qbit     = ~w_diff[33];
        w_rem_next = w_qbit ? w_diff[32:0] : w_shift[32:0];
        w_quo_next = {r_dvd[30:0], w_qbit};
        w_lo_fin   = (r_signed && r_qsign) ? -w_quo_next : w_quo_next;
        w_hi_fin   = (r_signed && r_rsign) ? -w_rem_next[31:0] : w_rem_next[31:0];
    end

    assign stall = ((r_state == c_IDLE) && start && !cancel) || (r_state == c_BUSY);
    assign done  = (r_state == c_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_count  <= 6'd0;
            r_dvd    <= 32'd0;
            r_dvs    <= 32'd0;
            r_rem    <= 33'd0;
            r_signed <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (cancel) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_signed <= is_signed;
                        r_qsign  <= dividend[31] ^ divisor[31];
                        r_rsign  <= dividend[31];
                        r_dvd    <= w_abs_dvd;
                        r_dvs    <= w_abs_dvs;
                        r_rem    <= 33'd0;
                        r_count  <= 6'd0;
                        if (divisor == 32'd0) begin
                            lo      <= 32'hFFFF_FFFF;
                            hi      <= dividend;
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_BUSY;
                        end
                    end
                end
                c_BUSY: begin
                    r_rem   <= w_rem_next;
                    r_dvd   <= w_quo_next;
                    r_count <= r_count + 6'd1;
                    if (r_count == 6'd31) begin
                        lo      <= w_lo_fin;
                        hi      <= w_hi_fin;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Self-checking bench for div_unit against an arithmetic reference
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    div_unit u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MIPS semantics: truncating division, remainder takes dividend's sign,
    // divide-by-zero returns all-ones quotient and the raw dividend.
    task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] eq, er;
        int k, st;
        model(s, a, b, eq, er);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        #1;
        check("stall_on_start", 32'(stall), 32'd1);
        tick();
        start = 1'b0;
        if (poke) begin
            start = 1'b1; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
        end
        k = 0; st = 0;
        while (done !== 1'b1 && k < 40) begin
            if (stall === 1'b1) st++;
            tick();
            k++;
            if (k == 2) start = 1'b0;
        end
        check("latency", 32'(k), (b == 32'd0) ? 32'd0 : 32'd32);
        check("busy_stall_cycles", 32'(st), (b == 32'd0) ? 32'd0 : 32'd32);
        check("stall_in_done", 32'(stall), 32'd0);
        check("lo", lo, eq);
        check("hi", hi, er);
        start = 1'b0;
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("stall_after_done", 32'(stall), 32'd0);
        check("lo_hold", lo, eq);
        check("hi_hold", hi, er);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1 || stall === 1'b1) seen++;
            tick();
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] prev_hi, prev_lo, a, b;
        bit s;
        int cls;

        rst = 1'b0; start = 1'b0; is_signed = 1'b0; cancel = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        start = 1'b1;
        #1;
        check("rst_stall_follows_start", 32'(stall), 32'd1);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        run_div(1'b0, 32'd100, 32'd7, 1'b0);
        check("divu_100_7_lo", lo, 32'd14);
        check("divu_100_7_hi", hi, 32'd2);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_div(1'b0, 32'h1234_5678, 32'd0, 1'b0);
        run_div(1'b1, 32'h8765_4321, 32'd0, 1'b1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);

        // Cancel during BUSY cycle 10
        prev_hi = hi; prev_lo = lo;
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        cancel = 1'b1;
        #1;
        check("stall_during_cancel", 32'(stall), 32'd1);
        tick();
        cancel = 1'b0;
        check("cancel_stall", 32'(stall), 32'd0);
        check("cancel_done", 32'(done), 32'd0);
        check("cancel_hi", hi, prev_hi);
        check("cancel_lo", lo, prev_lo);
        expect_quiet("cancel_no_done", 40);
        run_div(1'b0, 32'd100, 32'd7, 1'b0);

        // Cancel overrides a simultaneous start
        start = 1'b1; cancel = 1'b1; dividend = 32'd50; divisor = 32'd5;
        #1;
        check("cancel_start_stall", 32'(stall), 32'd0);
        tick();
        start = 1'b0; cancel = 1'b0;
        expect_quiet("cancel_start_ignored", 36);

        // Asynchronous reset mid-BUSY
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        #3;
        rst = 1'b1;
        tick();
        expect_quiet("arst_no_done", 40);
        run_div(1'b0, 32'd9, 32'd3, 1'b0);
        check("after_rst_lo", lo, 32'd3);
        check("after_rst_hi", hi, 32'd0);

        for (int it = 0; it < 40; it++) begin
            s   = 1'($urandom);
            a   = $urandom;
            cls = $urandom_range(0, 4);
            case (cls)
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = 32'd0;
                3: b = -32'($urandom_range(1, 15));
                default: begin a = $urandom_range(0, 1000); b = $urandom | 32'h0001_0000; end
            endcase
            run_div(s, a, b, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
